// File: rtl/imem_loader.sv
// Boot-time IMEM writer: assembles little-endian words from a byte stream and
// writes them at consecutive addresses, holding the core in reset until done.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, FLUSH, RUN} state_t;

    state_t      state, state_d;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [16:0] word_idx;
    logic [23:0] asm_q;
    logic        xfer;
    logic        word_done;
    logic        last_word;
    logic        in_range;

    assign xfer      = in_valid && in_ready;
    assign last_word = (word_idx == ({1'b0, count} - 17'd1));
    assign in_range  = (word_idx < 17'(DEPTH));

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        word_done = 1'b0;
        case (state)
            CNT_LO: begin
                in_ready = 1'b1;
                if (xfer) state_d = CNT_HI;
            end
            CNT_HI: begin
                in_ready = 1'b1;
                if (xfer) state_d = ({in_data, count[7:0]} == 16'd0) ? RUN : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                if (xfer && byte_idx == 2'd3) begin
                    word_done = 1'b1;
                    if (last_word) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = state;
        endcase
        // reload wins over any byte accepted in the same cycle
        if (reload) state_d = CNT_LO;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= CNT_LO;
            count      <= '0;
            byte_idx   <= '0;
            word_idx   <= '0;
            asm_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state     <= state_d;
            core_hold <= (state_d != RUN);
            done      <= (state_d == RUN);
            imem_we   <= 1'b0;
            if (reload) begin
                count    <= '0;
                byte_idx <= '0;
                word_idx <= '0;
                asm_q    <= '0;
                err      <= 1'b0;
            end else if (xfer) begin
                case (state)
                    CNT_LO: count[7:0] <= in_data;
                    CNT_HI: begin
                        count[15:8] <= in_data;
                        byte_idx    <= '0;
                        word_idx    <= '0;
                    end
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        // shift in from the top; after three bytes asm_q = {b2, b1, b0}
                        asm_q    <= {in_data, asm_q[23:8]};
                        if (word_done) begin
                            word_idx <= word_idx + 17'd1;
                            if (in_range) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx[ADDR_W-1:0];
                                imem_wdata <= {in_data, asm_q};
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default instance and a DEPTH=4 instance
// share the stimulus; writes are logged on the falling edge and compared.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        reload;

    logic        in_ready, imem_we, core_hold, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    logic        in_ready4, imem_we4, core_hold4, done4, err4;
    logic [1:0]  imem_addr4;
    logic [31:0] imem_wdata4;

    int n_checks = 0;
    int n_errors = 0;

    int          we_cnt, we_cnt4;
    logic [31:0] wr_addr[$], wr_data[$], wr_addr4[$], wr_data4[$];
    logic [7:0]  stream[$];

    always #5 clk = ~clk;

    imem_loader u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .done(done), .err(err)
    );

    imem_loader #(.ADDR_W(2), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .reload(reload), .imem_we(imem_we4),
        .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
        .core_hold(core_hold4), .done(done4), .err(err4)
    );

    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt++;
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
        if (imem_we4) begin
            we_cnt4++;
            wr_addr4.push_back(32'(imem_addr4));
            wr_data4.push_back(imem_wdata4);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        we_cnt  = 0;
        we_cnt4 = 0;
        wr_addr.delete();
        wr_data.delete();
        wr_addr4.delete();
        wr_data4.delete();
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] addr, input logic [31:0] data);
        if (wr_addr.size() > idx) begin
            check({tag, "_addr"}, wr_addr[idx], addr);
            check({tag, "_data"}, wr_data[idx], data);
        end else begin
            check({tag, "_missing"}, 32'(wr_addr.size()), 32'(idx + 1));
        end
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic send_stream(input int gap);
        foreach (stream[i]) begin
            in_data  = stream[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; reload = 1'b0;
        clear_log();
        #12;
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        check("rst_we",   32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        #10 rst = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // 1: two-word load
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00};
        send_stream(0);
        check("t1_flush_ready", 32'(in_ready), 32'd0);
        check("t1_flush_we",    32'(imem_we), 32'd1);
        check("t1_flush_hold",  32'(core_hold), 32'd1);
        check("t1_flush_addr",  32'(imem_addr), 32'd1);
        check("t1_flush_wdata", imem_wdata, 32'h0000_1237);
        @(posedge clk); #1;
        check("t1_run_we",    32'(imem_we), 32'd0);
        check("t1_run_hold",  32'(core_hold), 32'd0);
        check("t1_run_done",  32'(done), 32'd1);
        check("t1_addr_hold", 32'(imem_addr), 32'd1);
        check("t1_data_hold", imem_wdata, 32'h0000_1237);
        check("t1_we_cnt", 32'(we_cnt), 32'd2);
        check_write("t1_w0", 0, 32'd0, 32'h0000_0013);
        check_write("t1_w1", 1, 32'd1, 32'h0000_1237);

        // 2: same stream with 3 idle cycles between bytes
        do_reload();
        check("t2_reload_hold", 32'(core_hold), 32'd1);
        check("t2_reload_done", 32'(done), 32'd0);
        check("t2_reload_ready", 32'(in_ready), 32'd1);
        clear_log();
        send_stream(3);
        check("t2_done", 32'(done), 32'd1);
        check("t2_we_cnt", 32'(we_cnt), 32'd2);
        check_write("t2_w0", 0, 32'd0, 32'h0000_0013);
        check_write("t2_w1", 1, 32'd1, 32'h0000_1237);

        // 3: zero-length program
        do_reload();
        clear_log();
        stream = '{8'h00, 8'h00};
        send_stream(0);
        check("t3_done",  32'(done), 32'd1);
        check("t3_hold",  32'(core_hold), 32'd0);
        check("t3_err",   32'(err), 32'd0);
        check("t3_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("t3_we_cnt", 32'(we_cnt), 32'd0);

        // 4: six words into the DEPTH=4 instance
        do_reload();
        clear_log();
        stream = '{8'h06, 8'h00};
        repeat (24) stream.push_back(8'hAA);
        send_stream(0);
        @(posedge clk); #1;
        check("t4_we_cnt4", 32'(we_cnt4), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wr_addr4.size() > i) begin
                check("t4_addr4", wr_addr4[i], 32'(i));
                check("t4_data4", wr_data4[i], 32'hAAAA_AAAA);
            end else begin
                check("t4_missing4", 32'(wr_addr4.size()), 32'(i + 1));
            end
        end
        check("t4_err4",  32'(err4), 32'd1);
        check("t4_done4", 32'(done4), 32'd1);
        check("t4_addr4_hold", 32'(imem_addr4), 32'd3);
        check("t4_err",   32'(err), 32'd0);
        check("t4_we_cnt", 32'(we_cnt), 32'd6);
        check_write("t4_w5", 5, 32'd5, 32'hAAAA_AAAA);

        // 5: reload with a simultaneous byte, then a one-word load
        in_data = 8'h55; in_valid = 1'b1; reload = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; reload = 1'b0;
        check("t5_hold",  32'(core_hold), 32'd1);
        check("t5_done",  32'(done), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        check("t5_err4",  32'(err4), 32'd0);
        clear_log();
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stream(0);
        @(posedge clk); #1;
        check("t5_done_run", 32'(done), 32'd1);
        check("t5_we_cnt", 32'(we_cnt), 32'd1);
        check_write("t5_w0", 0, 32'd0, 32'hDEAD_BEEF);

        // 6: asynchronous reset in the middle of a two-word load
        do_reload();
        clear_log();
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(0);
        #1 rst = 1'b0;
        #1;
        check("t6_we",    32'(imem_we), 32'd0);
        check("t6_hold",  32'(core_hold), 32'd1);
        check("t6_done",  32'(done), 32'd0);
        check("t6_err",   32'(err), 32'd0);
        check("t6_addr",  32'(imem_addr), 32'd0);
        check("t6_wdata", imem_wdata, 32'd0);
        check("t6_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        clear_log();
        stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h21, 8'h43, 8'h65, 8'h87};
        send_stream(0);
        @(posedge clk); #1;
        check("t6_done_run", 32'(done), 32'd1);
        check("t6_we_cnt", 32'(we_cnt), 32'd2);
        check_write("t6_w0", 0, 32'd0, 32'h1234_5678);
        check_write("t6_w1", 1, 32'd1, 32'h8765_4321);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory: the counterpart to the core's fetch path, which only reads IMEM.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word through the IMEM write port at consecutive word addresses starting at 0.
- Holds the core (pc, dec, alu pipeline) in reset until the whole program has been written.

Parameters:
- ADDR_W, 8, IMEM word-address width.
- DEPTH, 256, number of IMEM words; words beyond DEPTH are discarded.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to restart loading.
- imem_we  output  1  IMEM write strobe, one cycle per word.
- imem_addr  output  ADDR_W  IMEM write word address.
- imem_wdata  output  32  IMEM write data.
- core_hold  output  1  active-high reset/stall to the core.
- done  output  1  program loaded; core running.
- err  output  1  word count exceeded DEPTH.

Behaviour:
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is decoded from state only, never from in_valid.
- States and in_ready:
  - CNT_LO: in_ready=1. Transfer latches count[7:0]; go to CNT_HI.
  - CNT_HI: in_ready=1. Transfer latches count[15:8]. If the 16-bit count N is 0, go to RUN. Otherwise go to DATA with byte_idx=0 and word_idx=0.
  - DATA: in_ready=1. Each transfer shifts into the assembly register; byte k fills bits [8k+7:8k]. byte_idx wraps 3→0. On the 4th byte: present imem_wdata and imem_addr=word_idx[ADDR_W-1:0]; pulse imem_we for exactly the next cycle; increment word_idx. If that was word N-1, go to FLUSH, else stay in DATA.
  - FLUSH: in_ready=0. One cycle only; the final imem_we pulse is active during it. Go to RUN.
  - RUN: in_ready=0. core_hold=0 and done=1. Stays here until reload.
- Write-strobe rules:
  - imem_we is registered and high only in the cycle after a word completes.
  - imem_addr and imem_wdata are stable in that cycle and hold their value afterwards.
- Overflow: if word_idx >= DEPTH when a word completes, imem_we stays 0 for that word and err is set. The bytes are still consumed so the stream stays aligned. err holds until reset or reload.
- core_hold is registered: core_hold = (state != RUN). It falls one cycle after the final imem_we pulse, so the core never fetches an unwritten word.
- Reset (rst=0, asynchronous):
  - State: CNT_LO; count, byte_idx, word_idx and the assembly register cleared.
  - Outputs: core_hold=1, done=0, err=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - in_ready=1 as soon as reset is released.
- reload (any state):
  - Next state CNT_LO; all counters cleared; done=0, err=0, core_hold=1.
  - imem_we is forced to 0 in the following cycle, which cancels any pending write.
  - reload has priority over a byte transfer in the same cycle; that byte is dropped.
- Reset mid-load: the partial word is lost. IMEM contents written so far are left as is.
- Widths: count is 16 bits; word_idx is 17 bits so that overflow past DEPTH is detectable.

Test Plan:
1. Reset, then stream 02 00, 13 00 00 00, 37 12 00 00 → imem_we pulses twice: addr0=0x00000013, addr1=0x00001237. in_ready=0 during FLUSH. core_hold falls one cycle after the second pulse. done=1.
2. Same stream with in_valid deasserted for 3 cycles between every byte → identical writes and values; no extra imem_we pulses.
3. Stream 00 00 → no imem_we pulse; RUN entered on the edge after the 2nd byte; core_hold=0, done=1, err=0.
4. DEPTH=4, count 06 00, 24 bytes AA..AA → 4 writes at addr 0–3 with 0xAAAAAAAA; err=1; the last 2 words are consumed without writes; done=1.
5. In RUN, pulse reload together with in_valid and byte 55 → 55 dropped; core_hold=1, done=0, state CNT_LO. Then 01 00 EF BE AD DE → addr0=0xDEADBEEF.
6. Drop rst low after 6 bytes of a 2-word load → all outputs return to reset values asynchronously (before the next clock edge). A fresh full load afterwards writes from addr 0.
